// File: rtl/ula_pkg.sv
// Shared types for the two-requester ALU arbiter: opcodes, FSM states, default width.
package ula_pkg;

   localparam int N_DEF = 16;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SSUB = 3'd1,
      OP_MUL  = 3'd2,
      OP_AND  = 3'd3,
      OP_OR   = 3'd4
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Codes above OP_OR are reserved and reported as errors.
   function automatic logic op_legal(input logic [2:0] op);
      return (op <= OP_OR);
   endfunction

endpackage

// File: rtl/ula.sv
// Combinational N-bit ALU: add, saturating subtract, low-half multiply, and, or.
// Zero latency, no flow control; reserved opcodes yield a zero result.
module ula
   import ula_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic [2:0]   i_op,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic [N-1:0] o_r,
   output logic         o_zero
);

   logic [N-1:0] w_r;

   always_comb begin
      w_r = '0;
      case (i_op)
         OP_ADD:  w_r = i_a + i_b;
         OP_SSUB: w_r = (i_a >= i_b) ? (i_a - i_b) : '0;
         OP_MUL:  w_r = i_a * i_b;
         OP_AND:  w_r = i_a & i_b;
         OP_OR:   w_r = i_a | i_b;
         default: w_r = '0;
      endcase
   end

   assign o_r    = w_r;
   assign o_zero = (w_r == '0);

endmodule

// File: rtl/ula_arb.sv
// Round-robin arbiter feeding one shared ALU; request-to-response 2 cycles, one op per 3 cycles.
// One op in flight: req_ready stays low outside IDLE, response held until rsp_ready.
module ula_arb
   import ula_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [1:0][2:0]     req_op,
   input  logic [1:0][N-1:0]   req_a,
   input  logic [1:0][N-1:0]   req_b,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_id,
   output logic [N-1:0]        rsp_r,
   output logic                rsp_zero,
   output logic                rsp_err,
   output logic                busy
);

   state_t       r_state;
   logic         r_ptr;
   logic         r_id;
   logic [2:0]   r_op;
   logic [N-1:0] r_a;
   logic [N-1:0] r_b;
   logic         r_rsp_valid;
   logic         r_rsp_id;
   logic [N-1:0] r_rsp_r;
   logic         r_rsp_zero;
   logic         r_rsp_err;
   logic         r_busy;

   logic         w_any;
   logic         w_gnt_id;
   logic [N-1:0] w_alu_r;
   logic         w_alu_zero;

   // Contention resolved by the pointer; a lone requester always wins.
   assign w_any    = |req_valid;
   assign w_gnt_id = (&req_valid) ? r_ptr : req_valid[1];

   assign req_ready = (r_state == ST_IDLE && rst_n && w_any) ? (2'b01 << w_gnt_id) : 2'b00;

   ula #(.N(N)) u_ula (
      .i_op   (r_op),
      .i_a    (r_a),
      .i_b    (r_b),
      .o_r    (w_alu_r),
      .o_zero (w_alu_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_ptr       <= 1'b0;
         r_id        <= 1'b0;
         r_op        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_r     <= '0;
         r_rsp_zero  <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_op    <= req_op[w_gnt_id];
                  r_a     <= req_a[w_gnt_id];
                  r_b     <= req_b[w_gnt_id];
                  r_id    <= w_gnt_id;
                  r_ptr   <= ~w_gnt_id;
                  r_busy  <= 1'b1;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_rsp_r     <= w_alu_r;
               r_rsp_zero  <= w_alu_zero;
               r_rsp_err   <= ~op_legal(r_op);
               r_rsp_id    <= r_id;
               r_rsp_valid <= 1'b1;
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_r     = r_rsp_r;
   assign rsp_zero  = r_rsp_zero;
   assign rsp_err   = r_rsp_err;
   assign busy      = r_busy;

endmodule

// File: tb/tb_ula_arb.sv
// Bench for ula_arb: directed requests push expected responses; a negedge monitor pops and compares.
module tb_ula_arb;

   logic             clk;
   logic             rst_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][2:0]  req_op;
   logic [1:0][15:0] req_a;
   logic [1:0][15:0] req_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [15:0]      rsp_r;
   logic             rsp_zero;
   logic             rsp_err;
   logic             busy;

   typedef struct {
      logic        id;
      logic [15:0] r;
      logic        z;
      logic        e;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   bit   prev_hold = 0;

   ula_arb #(.N(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_r     (rsp_r),
      .rsp_zero  (rsp_zero),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input int id, input logic [15:0] r, input logic z, input logic e);
      exp_t x;
      x.id  = id[0];
      x.r   = r;
      x.z   = z;
      x.e   = e;
      x.cyc = cyc;
      q.push_back(x);
   endtask

   task automatic start(input int id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      @(posedge clk); #1;
      req_op[id]    = op;
      req_a[id]     = a;
      req_b[id]     = b;
      req_valid[id] = 1'b1;
   endtask

   // Waits for the handshake of requester id, records expectation, then drops valid.
   task automatic finish(input int id, input logic [15:0] r, input logic z, input logic e, input bit push);
      bit got = 0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if (req_valid[id] && req_ready[id]) got = 1;
      end
      chk(got, "grant_timeout", {31'd0, got}, 32'd1);
      if (got && push) push_exp(id, r, z, e);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic issue(input int id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] r, input logic z, input logic e);
      start(id, op, a, b);
      finish(id, r, z, e, 1'b1);
   endtask

   task automatic drain();
      bit done = 0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         if (q.size() == 0 && !busy) done = 1;
      end
      chk(done, "drain_timeout", q.size(), 32'd0);
   endtask

   // Monitor: every presented response is compared against the scoreboard head.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold = 0;
      end else begin
         chk(req_ready != 2'b11, "ready_onehot", {30'd0, req_ready}, 32'd0);
         if (rsp_valid) begin
            if (q.size() == 0) begin
               chk(1'b0, "unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
            end else begin
               if (!prev_hold)
                  chk(cyc == q[0].cyc + 2, "latency", cyc - q[0].cyc, 32'd2);
               chk(rsp_id == q[0].id, "rsp_id", {31'd0, rsp_id}, {31'd0, q[0].id});
               chk(rsp_r == q[0].r, "rsp_r", {16'd0, rsp_r}, {16'd0, q[0].r});
               chk(rsp_zero == q[0].z, "rsp_zero", {31'd0, rsp_zero}, {31'd0, q[0].z});
               chk(rsp_err == q[0].e, "rsp_err", {31'd0, rsp_err}, {31'd0, q[0].e});
               chk(req_ready == 2'b00, "ready_in_resp", {30'd0, req_ready}, 32'd0);
               if (rsp_ready) void'(q.pop_front());
            end
         end
         prev_hold = rsp_valid && !rsp_ready;
      end
   end

   initial begin
      int g;
      rst_n     = 1'b0;
      req_valid = 2'b00;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;

      #12;
      chk(req_ready == 2'b00, "rst_ready", {30'd0, req_ready}, 32'd0);
      chk({rsp_valid, rsp_id, rsp_zero, rsp_err, busy} == 5'b0, "rst_flags",
          {27'd0, rsp_valid, rsp_id, rsp_zero, rsp_err, busy}, 32'd0);
      chk(rsp_r == 16'h0000, "rst_r", {16'd0, rsp_r}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      issue(0, 3'b000, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0);
      issue(1, 3'b001, 16'h0002, 16'h0005, 16'h0000, 1'b1, 1'b0);
      issue(1, 3'b001, 16'h0009, 16'h0002, 16'h0007, 1'b0, 1'b0);
      issue(0, 3'b010, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0);
      issue(1, 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
      issue(0, 3'b011, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0);
      drain();

      // A requester that withdraws before it is granted must not be captured.
      issue(0, 3'b100, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0);
      req_op[1] = 3'b000; req_a[1] = 16'h0001; req_b[1] = 16'h0001; req_valid[1] = 1'b1;
      @(negedge clk);
      chk(req_ready == 2'b00, "ready_in_exec", {30'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      drain();

      // Illegal opcode with the consumer stalled; a waiting request must not be accepted.
      rsp_ready = 1'b0;
      issue(1, 3'b111, 16'h0005, 16'h0003, 16'h0000, 1'b1, 1'b1);
      start(0, 3'b000, 16'h0001, 16'h0002);
      repeat (6) @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      finish(0, 16'h0003, 1'b0, 1'b0, 1'b1);
      drain();

      // Reset while the ALU stage is occupied discards the operation.
      start(0, 3'b000, 16'h0005, 16'h0005);
      finish(0, 16'h000A, 1'b0, 1'b0, 1'b0);
      chk(busy == 1'b1, "busy_in_exec", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk(req_ready == 2'b00, "midrst_ready", {30'd0, req_ready}, 32'd0);
      chk({rsp_valid, rsp_id, rsp_zero, rsp_err, busy} == 5'b0, "midrst_flags",
          {27'd0, rsp_valid, rsp_id, rsp_zero, rsp_err, busy}, 32'd0);
      chk(rsp_r == 16'h0000, "midrst_r", {16'd0, rsp_r}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk(!rsp_valid && !busy, "no_rsp_after_rst", {30'd0, rsp_valid, busy}, 32'd0);

      // Both requesters held valid: grants must alternate starting from requester 0.
      @(posedge clk); #1;
      req_op[0] = 3'b000; req_a[0] = 16'h0001; req_b[0] = 16'h0001;
      req_op[1] = 3'b100; req_a[1] = 16'h00F0; req_b[1] = 16'h000F;
      req_valid = 2'b11;
      g = 0;
      for (int k = 0; k < 60 && g < 4; k++) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin
            chk(req_ready[1] == g[0], "rr_order", {31'd0, req_ready[1]}, {31'd0, g[0]});
            if (req_ready[1]) push_exp(1, 16'h00FF, 1'b0, 1'b0);
            else              push_exp(0, 16'h0002, 1'b0, 1'b0);
            g++;
         end
      end
      chk(g == 4, "rr_grant_count", g, 32'd4);
      @(posedge clk); #1;
      req_valid = 2'b00;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
